// File: rtl/epwm_pkg.sv
// Shared types and default sizing for the multi-channel pulse generator.
package epwm_pkg;

    localparam int unsigned DefaultWidth    = 4;
    localparam int unsigned DefaultChannels = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDelay = 2'd1,
        StHigh  = 2'd2
    } ch_state_e;

endpackage

// File: rtl/epwm_ch.sv
// One pulse channel: shadow/active timing registers and IDLE/DELAY/HIGH sequencer.
module epwm_ch
    import epwm_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             one_shot,
    input  logic             start,
    input  logic             wr,
    input  logic [WIDTH-1:0] d_in,
    input  logic [WIDTH-1:0] w_in,
    output logic             pulse,
    output logic             period_end,
    output logic             busy
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [WIDTH-1:0] d_sh_q, w_sh_q;
    logic [WIDTH-1:0] d_act_q, w_act_q;
    logic [WIDTH-1:0] cnt_q;
    ch_state_e        state_q;
    logic             pulse_q, period_end_q, busy_q;

    logic delay_done, high_done, period_last, idle_start, begin_period, zero_start;

    assign delay_done   = (state_q == StDelay) && (cnt_q == d_act_q - One);
    assign high_done    = (state_q == StHigh) && (cnt_q == w_act_q - One);
    // A zero-width period ends with the delay phase.
    assign period_last  = high_done || (delay_done && (w_act_q == '0));
    assign idle_start   = (state_q == StIdle) && start;
    // Continuous channels roll straight into the next period; one_shot is only looked at here.
    assign begin_period = idle_start || (period_last && !one_shot);
    // An empty period started from idle never leaves idle but still owes its end strobe.
    assign zero_start   = idle_start && (d_sh_q == '0) && (w_sh_q == '0);

    // Shadow registers take configuration writes; kept while disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_sh_q <= '0;
            w_sh_q <= '0;
        end else if (wr) begin
            d_sh_q <= d_in;
            w_sh_q <= w_in;
        end
    end

    // Channel sequencer; outputs are registered copies of the previous cycle's state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            d_act_q      <= '0;
            w_act_q      <= '0;
            pulse_q      <= 1'b0;
            period_end_q <= 1'b0;
            busy_q       <= 1'b0;
        end else if (!en) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            pulse_q      <= 1'b0;
            period_end_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            pulse_q      <= (state_q == StHigh);
            busy_q       <= (state_q != StIdle);
            period_end_q <= period_last || zero_start;
            if (begin_period) begin
                // Active copies pre-write shadow, so a same-cycle load lands next period.
                d_act_q <= d_sh_q;
                w_act_q <= w_sh_q;
                cnt_q   <= '0;
                if (d_sh_q != '0) begin
                    state_q <= StDelay;
                end else if (w_sh_q != '0) begin
                    state_q <= StHigh;
                end else begin
                    state_q <= StIdle;
                end
            end else if (period_last) begin
                state_q <= StIdle;
                cnt_q   <= '0;
            end else if (delay_done) begin
                state_q <= StHigh;
                cnt_q   <= '0;
            end else if (state_q != StIdle) begin
                cnt_q <= cnt_q + One;
            end
        end
    end

    assign pulse      = pulse_q;
    assign period_end = period_end_q;
    assign busy       = busy_q;

endmodule

// File: rtl/epwm_mc.sv
// Multi-channel pulse generator: configuration write decode plus one epwm_ch per channel.
module epwm_mc
    import epwm_pkg::*;
#(
    parameter int unsigned WIDTH    = DefaultWidth,
    parameter int unsigned CHANNELS = DefaultChannels,
    localparam int unsigned SelW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [CHANNELS-1:0] one_shot,
    input  logic [CHANNELS-1:0] start,
    input  logic                load,
    input  logic [SelW-1:0]     ch_sel,
    input  logic [WIDTH-1:0]    d_in,
    input  logic [WIDTH-1:0]    w_in,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] period_end,
    output logic [CHANNELS-1:0] busy
);

    logic [CHANNELS-1:0] wr;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        // Selects beyond the last channel match nothing and are dropped.
        assign wr[i] = load && (32'(ch_sel) == i);

        epwm_ch #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .one_shot  (one_shot[i]),
            .start     (start[i]),
            .wr        (wr[i]),
            .d_in      (d_in),
            .w_in      (w_in),
            .pulse     (pulse[i]),
            .period_end(period_end[i]),
            .busy      (busy[i])
        );
    end

endmodule

// File: tb/tb_epwm_mc.sv
// Directed bench for epwm_mc at WIDTH=4, CHANNELS=4.
module tb_epwm_mc;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] one_shot;
    logic [3:0] start;
    logic       load;
    logic [1:0] ch_sel;
    logic [3:0] d_in;
    logic [3:0] w_in;
    logic [3:0] pulse;
    logic [3:0] period_end;
    logic [3:0] busy;

    int vectors = 0;
    int miscompares = 0;

    epwm_mc #(
        .WIDTH   (4),
        .CHANNELS(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .one_shot  (one_shot),
        .start     (start),
        .load      (load),
        .ch_sel    (ch_sel),
        .d_in      (d_in),
        .w_in      (w_in),
        .pulse     (pulse),
        .period_end(period_end),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [3:0] d, input logic [3:0] w);
        load   = 1'b1;
        ch_sel = ch;
        d_in   = d;
        w_in   = w;
        tick();
        load   = 1'b0;
    endtask

    logic exp_p, exp_e;

    initial begin
        reset    = 1'b1;
        en       = 1'b1;
        one_shot = '0;
        start    = '0;
        load     = 1'b0;
        ch_sel   = '0;
        d_in     = '0;
        w_in     = '0;

        // Reset state
        #2 reset = 1'b0;
        #2;
        check("rst_pulse", 32'(pulse), 32'h0);
        check("rst_pend", 32'(period_end), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        tick();
        tick();
        #2 reset = 1'b1;
        tick();

        // ch0 d=3 w=2 continuous, reconfigured mid-DELAY of the third period to d=1 w=4
        cfg(2'd0, 4'd3, 4'd2);
        start = 4'b0001;
        tick();
        start = '0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k <= 15) begin
                exp_p = ((k - 1) % 5) >= 3;
                exp_e = ((k - 1) % 5) == 4;
            end else begin
                exp_p = (k >= 17);
                exp_e = (k == 20);
            end
            check($sformatf("ch0_pulse@%0d", k), 32'(pulse[0]), 32'(exp_p));
            check($sformatf("ch0_pend@%0d", k), 32'(period_end[0]), 32'(exp_e));
            if (k == 1) check("ch0_busy@1", 32'(busy[0]), 32'h1);
            if (k == 11) begin
                load   = 1'b1;
                ch_sel = 2'd0;
                d_in   = 4'd1;
                w_in   = 4'd4;
            end
            if (k == 12) load = 1'b0;
        end

        // en low during DELAY forces idle on the next edge
        en = 1'b0;
        tick();
        check("en0_pulse", 32'(pulse[0]), 32'h0);
        check("en0_busy", 32'(busy[0]), 32'h0);
        check("en0_pend", 32'(period_end[0]), 32'h0);
        en = 1'b1;
        tick();
        check("en1_idle_busy", 32'(busy[0]), 32'h0);

        // Shadow d=1 w=4 survived en low; run it one-shot
        one_shot = 4'b0001;
        start    = 4'b0001;
        tick();
        start = '0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_p = (k >= 2) && (k <= 5);
            check($sformatf("ch0_os_pulse@%0d", k), 32'(pulse[0]), 32'(exp_p));
            check($sformatf("ch0_os_pend@%0d", k), 32'(period_end[0]), 32'(k == 5));
        end
        check("ch0_os_busy_end", 32'(busy[0]), 32'h0);

        // ch1 one-shot d=0 w=15
        cfg(2'd1, 4'd0, 4'd15);
        one_shot = 4'b0011;
        start    = 4'b0010;
        tick();
        start = '0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            check($sformatf("ch1_pulse@%0d", k), 32'(pulse[1]), 32'(k <= 15));
            check($sformatf("ch1_pend@%0d", k), 32'(period_end[1]), 32'(k == 15));
            check($sformatf("ch1_busy@%0d", k), 32'(busy[1]), 32'(k <= 15));
        end

        // ch2 empty period: one end strobe, never busy, never high
        cfg(2'd2, 4'd0, 4'd0);
        start = 4'b0100;
        tick();
        check("ch2_zero_pend@1", 32'(period_end[2]), 32'h1);
        check("ch2_zero_busy@1", 32'(busy[2]), 32'h0);
        check("ch2_zero_pulse@1", 32'(pulse[2]), 32'h0);
        start = '0;
        tick();
        check("ch2_zero_pend@2", 32'(period_end[2]), 32'h0);
        check("ch2_zero_busy@2", 32'(busy[2]), 32'h0);

        // Async reset in the middle of a HIGH phase
        start = 4'b0010;
        tick();
        start = '0;
        tick();
        tick();
        tick();
        check("ch1_high_before_rst", 32'(pulse[1]), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_pulse", 32'(pulse), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        tick();
        #2 reset = 1'b1;
        tick();

        // Four channels started together
        one_shot = '0;
        cfg(2'd0, 4'd1, 4'd1);
        cfg(2'd1, 4'd2, 4'd3);
        cfg(2'd2, 4'd0, 4'd4);
        cfg(2'd3, 4'd5, 4'd0);
        start = 4'b1111;
        tick();
        start = '0;
        for (int k = 1; k <= 20; k++) begin
            logic [3:0] ep, ee;
            tick();
            ep[0] = ((k - 1) % 2) == 1;
            ep[1] = ((k - 1) % 5) >= 2;
            ep[2] = 1'b1;
            ep[3] = 1'b0;
            ee[0] = ((k - 1) % 2) == 1;
            ee[1] = ((k - 1) % 5) == 4;
            ee[2] = ((k - 1) % 4) == 3;
            ee[3] = ((k - 1) % 5) == 4;
            check($sformatf("multi_pulse@%0d", k), 32'(pulse), 32'(ep));
            check($sformatf("multi_pend@%0d", k), 32'(period_end), 32'(ee));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/epwm_mc.md
EPWM_MC -- requirements
Module: epwm_mc

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, bit width of delay, width and counter values.
REQ-002 SHALL provide parameter CHANNELS, default 4, number of independent pulse channels (1..16).
REQ-003 SHALL provide port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port en  input  1  global enable; low forces all channels idle.
REQ-006 SHALL provide port one_shot  input  CHANNELS  per-channel mode: 1 = single period then idle, 0 = continuous.
REQ-007 SHALL provide port start  input  CHANNELS  per-channel start request, sampled each clk.
REQ-008 SHALL provide port load  input  1  write strobe for configuration.
REQ-009 SHALL provide port ch_sel  input  clog2(CHANNELS) (min 1)  channel targeted by load.
REQ-010 SHALL provide port d_in  input  WIDTH  low-phase (delay) length in cycles.
REQ-011 SHALL provide port w_in  input  WIDTH  high-phase (width) length in cycles.
REQ-012 SHALL provide port pulse  output  CHANNELS  per-channel PWM output, registered.
REQ-013 SHALL provide port period_end  output  CHANNELS  one-cycle strobe on last cycle of each period.
REQ-014 SHALL provide port busy  output  CHANNELS  high while channel not IDLE.

Function
REQ-015 Each channel SHALL hold shadow (d_sh, w_sh) and active (d_act, w_act) registers; load with ch_sel in range SHALL write d_in/w_in to that channel's shadow only; ch_sel >= CHANNELS SHALL be ignored.
REQ-016 Active SHALL copy shadow at every period start (IDLE->run on start, or end of HIGH in continuous mode); a load in the same cycle as a period start SHALL NOT affect that period (active takes pre-write shadow).
REQ-017 Each channel SHALL run FSM IDLE/DELAY/HIGH with a WIDTH-bit counter cnt.
REQ-018 IDLE: on start=1 with en=1, load active; go DELAY if d>0, else HIGH if w>0, else stay IDLE with period_end pulsed next cycle; cnt<=0.
REQ-019 DELAY: cnt increments; at cnt==d_act-1 go HIGH, cnt<=0; duration exactly d_act cycles.
REQ-020 HIGH: cnt increments; at cnt==w_act-1 assert period_end for that cycle; then one_shot=1 -> IDLE, else start next period per REQ-018 rules using fresh shadow; duration exactly w_act cycles.
REQ-021 pulse SHALL be 1 exactly in cycles where state==HIGH, driven from a flop; busy = (state!=IDLE).
REQ-022 Period length SHALL be d_act+w_act cycles (max 2*(2^WIDTH-1)); counters SHALL never wrap.
REQ-023 Continuous with next active d=0,w=0 SHALL return to IDLE, pulse low.
REQ-024 start while busy SHALL be ignored; one_shot change SHALL be sampled only at end of HIGH.
REQ-025 en=0 SHALL synchronously move all channels to IDLE, pulse=0, period_end=0 next cycle; shadows retained.

Reset
REQ-026 reset=0 SHALL asynchronously clear state to IDLE and cnt, shadow, active, pulse, period_end, busy to 0.
REQ-027 Deassertion SHALL take effect at the next rising clk; reset mid-HIGH SHALL drop pulse immediately.

Structure
REQ-028 Package epwm_pkg SHALL hold the channel state enum (IDLE, DELAY, HIGH) and default WIDTH/CHANNELS constants.
REQ-029 Per-channel logic SHALL be sub-module epwm_ch, instantiated CHANNELS times via generate; top holds load decode only.

Verification
REQ-030 WIDTH=4: load ch0 d=3 w=2, continuous, start at edge T -> pulse0 low T+1..T+3, high T+4..T+5, period_end0 at T+5, repeats every 5 cycles.
REQ-031 one_shot ch1 d=0 w=15 -> pulse1 high 15 cycles from T+1, period_end1 at T+15, busy1 low from T+16, no restart.
REQ-032 ch0 running d=3 w=2, load d=1 w=4 mid-DELAY -> current period unchanged, next period low 1 / high 4.
REQ-033 d=0 w=0 start -> pulse stays 0, busy 0, single period_end strobe.
REQ-034 async reset asserted mid-HIGH (between edges) -> pulse 0 immediately; en=0 during DELAY -> IDLE next cycle, shadows intact.
REQ-035 four channels started same cycle with (1,1),(2,3),(0,4),(5,0) -> independent periods 2,5,4,5; pulse3 never high.
